// File: rtl/datapath_irqstk_if.sv
// datapath_irqstk_if: decoder controls, memory buses and status flags of the datapath
interface datapath_irqstk_if #(
   parameter int WIDTH     = 16,
   parameter int AW        = 16,
   parameter int NREGS     = 16,
   parameter int IMM_W     = 4,
   parameter int IRQ_DEPTH = 4
);
   localparam int RW    = $clog2(NREGS);
   localparam int PRE_W = WIDTH - IMM_W;
   localparam int DW    = $clog2(IRQ_DEPTH + 1);
   logic             i_exec_ce;
   logic [AW-1:0]    i_rst_ad;
   logic [RW-1:0]    i_rd;
   logic [RW-1:0]    i_rs;
   logic [IMM_W-1:0] i_imm;
   logic             i_imm_pre;
   logic [PRE_W-1:0] i_pre;
   logic             i_src_imm;
   logic [2:0]       i_op;
   logic             i_upd_cc;
   logic             i_rf_we;
   logic [1:0]       i_wb_sel;
   logic             i_is_jal;
   logic             i_br_taken;
   logic [7:0]       i_disp;
   logic             i_irq_take;
   logic [AW-1:0]    i_irq_vector;
   logic             i_reti;
   logic [WIDTH-1:0] i_data_in;
   logic [WIDTH-1:0] o_data_out;
   logic [AW-1:0]    o_pc;
   logic [AW-1:0]    o_d_ad;
   logic [3:0]       o_cc;
   logic [DW-1:0]    o_irq_depth;
   logic             o_stk_ovf;
   logic             o_stk_unf;
   modport master (
      output i_exec_ce, i_rst_ad, i_rd, i_rs, i_imm, i_imm_pre, i_pre, i_src_imm, i_op,
             i_upd_cc, i_rf_we, i_wb_sel, i_is_jal, i_br_taken, i_disp, i_irq_take,
             i_irq_vector, i_reti, i_data_in,
      input  o_data_out, o_pc, o_d_ad, o_cc, o_irq_depth, o_stk_ovf, o_stk_unf
   );
   modport slave (
      input  i_exec_ce, i_rst_ad, i_rd, i_rs, i_imm, i_imm_pre, i_pre, i_src_imm, i_op,
             i_upd_cc, i_rf_we, i_wb_sel, i_is_jal, i_br_taken, i_disp, i_irq_take,
             i_irq_vector, i_reti, i_data_in,
      output o_data_out, o_pc, o_d_ad, o_cc, o_irq_depth, o_stk_ovf, o_stk_unf
   );
endinterface

// File: rtl/datapath_irqstk.sv
// datapath_irqstk: regfile, ALU, flags, PC/branch logic and a single-cycle {PC,PSW} interrupt stack
module datapath_irqstk #(
   parameter int WIDTH     = 16,
   parameter int AW        = 16,
   parameter int NREGS     = 16,
   parameter int IMM_W     = 4,
   parameter int IRQ_DEPTH = 4
) (
   input logic              i_clk,
   input logic              i_rst_n,
   datapath_irqstk_if.slave bus
);
   localparam int DW = $clog2(IRQ_DEPTH + 1);
   localparam int SW = (IRQ_DEPTH > 1) ? $clog2(IRQ_DEPTH) : 1;
   logic [WIDTH-1:0] r_rf [NREGS];
   logic [AW-1:0]    r_stk_pc [IRQ_DEPTH];
   logic [4:0]       r_stk_psw [IRQ_DEPTH];
   logic [AW-1:0]    r_pc;
   logic [3:0]       r_cc;
   logic             r_cl;
   logic [DW-1:0]    r_depth;
   logic             r_ovf, r_unf;
   logic [WIDTH-1:0] w_imm, w_a, w_b, w_bx, w_res, w_wb;
   logic [WIDTH:0]   w_add;
   logic             w_sub, w_cin, w_c, w_v, w_full, w_empty, w_push, w_pop, w_cl_nxt;
   logic [3:0]       w_cc_nxt;
   logic [4:0]       w_psw;
   logic [AW-1:0]    w_off, w_pc2, w_br, w_seq, w_pc_nxt;
   logic [SW-1:0]    w_top, w_wr;
   // ALU: subtracts compute B-A as B+~A+cin; shifts move B right and expose bit 0 as carry
   always_comb begin
      w_imm = bus.i_imm_pre ? {bus.i_pre, bus.i_imm} : WIDTH'($signed(bus.i_imm));
      w_a   = bus.i_src_imm ? w_imm : r_rf[bus.i_rd];
      w_b   = r_rf[bus.i_rs];
      w_sub = ~bus.i_op[2] & bus.i_op[0];
      w_cin = bus.i_op[1] ? (bus.i_op[0] ^ r_cl) : bus.i_op[0];
      w_bx  = w_sub ? ~w_a : w_a;
      w_add = {1'b0, w_b} + {1'b0, w_bx} + (WIDTH+1)'(w_cin);
      w_res = ~bus.i_op[2] ? w_add[WIDTH-1:0] :
              bus.i_op[1]  ? {bus.i_op[0] & w_b[WIDTH-1], w_b[WIDTH-1:1]} :
              bus.i_op[0]  ? (w_a ^ w_b) : (w_a & w_b);
      w_c   = bus.i_op[2] ? (bus.i_op[1] & w_b[0]) : (w_add[WIDTH] ^ w_sub);
      w_v   = ~bus.i_op[2] & (w_b[WIDTH-1] == w_bx[WIDTH-1]) & (w_add[WIDTH-1] != w_b[WIDTH-1]);
      w_psw = {r_cl, r_cc};
      w_wb  = bus.i_wb_sel == 2'd0 ? w_res :
              bus.i_wb_sel == 2'd1 ? bus.i_data_in :
              bus.i_wb_sel == 2'd2 ? WIDTH'(w_pc2) : WIDTH'(w_psw);
   end
   // Next PC, stack pointers and next flags; irq entry overrides reti and the instruction's flag update
   always_comb begin
      w_pc2    = r_pc + AW'(2);
      w_off    = AW'($signed(bus.i_disp));
      w_br     = r_pc + {w_off[AW-2:0], 1'b0};
      w_seq    = bus.i_is_jal ? w_add[AW-1:0] : bus.i_br_taken ? w_br : w_pc2;
      w_full   = r_depth == DW'(IRQ_DEPTH);
      w_empty  = r_depth == '0;
      w_push   = bus.i_irq_take & ~w_full;
      w_pop    = bus.i_reti & ~bus.i_irq_take & ~w_empty;
      w_top    = SW'(r_depth - DW'(1));
      w_wr     = SW'(r_depth);
      w_pc_nxt = bus.i_irq_take ? bus.i_irq_vector :
                 w_pop          ? r_stk_pc[w_top] :
                 bus.i_reti     ? w_pc2 : w_seq;
      {w_cl_nxt, w_cc_nxt} = bus.i_irq_take ? 5'd0 :
                             w_pop ? r_stk_psw[w_top] :
                             (bus.i_reti | ~bus.i_upd_cc) ? w_psw :
                             {~bus.i_op[2] & bus.i_op[1] & w_c, w_res == '0, w_res[WIDTH-1], w_c, w_v};
   end
   // Register file write port; suppressed during reset and stalls
   always_ff @(posedge i_clk) begin
      if (i_rst_n && bus.i_exec_ce && bus.i_rf_we) r_rf[bus.i_rd] <= w_wb;
   end
   // Interrupt frame push: return PC ignores the irq redirect, PSW is the pre-instruction value
   always_ff @(posedge i_clk) begin
      if (i_rst_n && bus.i_exec_ce && w_push) begin
         r_stk_pc[w_wr]  <= w_seq;
         r_stk_psw[w_wr] <= w_psw;
      end
   end
   // Architectural state: PC, flags, carry latch, stack depth and sticky error flags
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc    <= bus.i_rst_ad;
         r_cc    <= '0;
         r_cl    <= 1'b0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (bus.i_exec_ce) begin
         r_pc <= w_pc_nxt;
         r_cc <= w_cc_nxt;
         r_cl <= w_cl_nxt;
         if (bus.i_irq_take) begin
            if (w_full) r_ovf <= 1'b1;
            else r_depth <= r_depth + DW'(1);
         end else if (bus.i_reti) begin
            if (w_empty) r_unf <= 1'b1;
            else r_depth <= r_depth - DW'(1);
         end
      end
   end
   assign bus.o_data_out  = r_rf[bus.i_rd];
   assign bus.o_pc        = r_pc;
   assign bus.o_d_ad      = w_add[AW-1:0];
   assign bus.o_cc        = r_cc;
   assign bus.o_irq_depth = r_depth;
   assign bus.o_stk_ovf   = r_ovf;
   assign bus.o_stk_unf   = r_unf;
endmodule

// File: tb/tb_datapath_irqstk.sv
// tb_datapath_irqstk: directed scenarios for the datapath with a two-frame interrupt stack
module tb_datapath_irqstk;
   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBC = 3'd3;
   localparam logic [2:0] AND = 3'd4, XOR = 3'd5, SRL = 3'd6, SRA = 3'd7;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [15:0] v;
   datapath_irqstk_if #(.IRQ_DEPTH(2)) bus();
   datapath_irqstk #(.IRQ_DEPTH(2)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      bus.i_exec_ce = 1'b1; bus.i_rd = '0; bus.i_rs = '0; bus.i_imm = '0; bus.i_imm_pre = 1'b0;
      bus.i_pre = '0; bus.i_src_imm = 1'b0; bus.i_op = ADD; bus.i_upd_cc = 1'b0; bus.i_rf_we = 1'b0;
      bus.i_wb_sel = 2'd0; bus.i_is_jal = 1'b0; bus.i_br_taken = 1'b0; bus.i_disp = '0;
      bus.i_irq_take = 1'b0; bus.i_irq_vector = '0; bus.i_reti = 1'b0; bus.i_data_in = '0;
   endtask

   task automatic exe;
      tick;
      clr;
   endtask

   task automatic do_reset(input logic [15:0] ad);
      bus.i_rst_ad = ad;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [3:0] r, input logic [15:0] d);
      clr;
      bus.i_rf_we = 1'b1; bus.i_wb_sel = 2'd1; bus.i_rd = r; bus.i_data_in = d;
      exe;
   endtask

   task automatic op_set(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic si, input logic [3:0] imm, input logic pe,
                         input logic [11:0] pre, input logic upd);
      bus.i_op = op; bus.i_rd = rd; bus.i_rs = rs; bus.i_src_imm = si; bus.i_imm = imm;
      bus.i_imm_pre = pe; bus.i_pre = pre; bus.i_upd_cc = upd; bus.i_rf_we = 1'b1; bus.i_wb_sel = 2'd0;
   endtask

   task automatic rdreg(input logic [3:0] r);
      bus.i_rd = r;
      #1;
      v = bus.o_data_out;
   endtask

   task automatic test_reset;
      clr;
      bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0040;
      do_reset(16'h0100);
      clr;
      checks++; if (bus.o_pc !== 16'h0100) begin failures++; $display("FAIL reset_pc got=%h exp=0100", bus.o_pc); end
      checks++; if (bus.o_cc !== 4'h0) begin failures++; $display("FAIL reset_cc got=%h exp=0", bus.o_cc); end
      checks++; if (bus.o_irq_depth !== 2'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", bus.o_irq_depth); end
      checks++; if ({bus.o_stk_ovf, bus.o_stk_unf} !== 2'b00) begin failures++; $display("FAIL reset_stk got=%b exp=00", {bus.o_stk_ovf, bus.o_stk_unf}); end
      repeat (3) tick;
      checks++; if (bus.o_pc !== 16'h0106) begin failures++; $display("FAIL idle_pc got=%h exp=0106", bus.o_pc); end
   endtask

   task automatic test_add_adc;
      load(4'd1, 16'hFFFF);
      load(4'd2, 16'h0001);
      op_set(ADD, 4'd1, 4'd2, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      checks++; if (bus.o_cc !== 4'b1010) begin failures++; $display("FAIL add_cc got=%b exp=1010", bus.o_cc); end
      rdreg(4'd1);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL add_res got=%h exp=0000", v); end
      op_set(ADC, 4'd2, 4'd2, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd2);
      checks++; if (v !== 16'h0002) begin failures++; $display("FAIL adc_nocarry got=%h exp=0002", v); end
      load(4'd4, 16'hFFFF);
      op_set(ADC, 4'd4, 4'd4, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      checks++; if (bus.o_cc !== 4'b0110) begin failures++; $display("FAIL adc_cc got=%b exp=0110", bus.o_cc); end
      op_set(ADC, 4'd2, 4'd2, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd2);
      checks++; if (v !== 16'h0005) begin failures++; $display("FAIL adc_carry got=%h exp=0005", v); end
   endtask

   task automatic test_sub_sbc;
      load(4'd6, 16'h0003);
      load(4'd7, 16'h0005);
      op_set(SUB, 4'd6, 4'd7, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd6);
      checks++; if (v !== 16'h0002) begin failures++; $display("FAIL sub_res got=%h exp=0002", v); end
      checks++; if (bus.o_cc !== 4'b0000) begin failures++; $display("FAIL sub_cc got=%b exp=0000", bus.o_cc); end
      op_set(SBC, 4'd7, 4'd6, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd7);
      checks++; if (v !== 16'hFFFD) begin failures++; $display("FAIL sbc_borrow got=%h exp=FFFD", v); end
      checks++; if (bus.o_cc !== 4'b0110) begin failures++; $display("FAIL sbc_cc got=%b exp=0110", bus.o_cc); end
      op_set(SBC, 4'd6, 4'd6, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd6);
      checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL sbc_chain got=%h exp=FFFF", v); end
      bus.i_rf_we = 1'b1; bus.i_wb_sel = 2'd3; bus.i_rd = 4'd8; exe;
      rdreg(4'd8);
      checks++; if (v !== 16'h0016) begin failures++; $display("FAIL psw_read got=%h exp=0016", v); end
   endtask

   task automatic test_logic;
      load(4'd9, 16'h8005);
      load(4'd10, 16'h0F0F);
      op_set(XOR, 4'd11, 4'd10, 1'b1, 4'hF, 1'b1, 12'hFFF, 1'b1); exe;
      rdreg(4'd11);
      checks++; if (v !== 16'hF0F0) begin failures++; $display("FAIL xor_res got=%h exp=F0F0", v); end
      checks++; if (bus.o_cc !== 4'b0100) begin failures++; $display("FAIL xor_cc got=%b exp=0100", bus.o_cc); end
      op_set(SRA, 4'd11, 4'd9, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd11);
      checks++; if (v !== 16'hC002) begin failures++; $display("FAIL sra_res got=%h exp=C002", v); end
      checks++; if (bus.o_cc !== 4'b0110) begin failures++; $display("FAIL sra_cc got=%b exp=0110", bus.o_cc); end
      op_set(SRL, 4'd12, 4'd9, 1'b0, 4'h0, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd12);
      checks++; if (v !== 16'h4002) begin failures++; $display("FAIL srl_res got=%h exp=4002", v); end
      checks++; if (bus.o_cc !== 4'b0010) begin failures++; $display("FAIL srl_cc got=%b exp=0010", bus.o_cc); end
      op_set(AND, 4'd13, 4'd9, 1'b1, 4'h8, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd13);
      checks++; if (v !== 16'h8000) begin failures++; $display("FAIL and_res got=%h exp=8000", v); end
      checks++; if (bus.o_cc !== 4'b0100) begin failures++; $display("FAIL and_cc got=%b exp=0100", bus.o_cc); end
   endtask

   task automatic test_imm;
      load(4'd0, 16'h0000);
      load(4'd1, 16'h7FFF);
      op_set(ADD, 4'd1, 4'd1, 1'b1, 4'h1, 1'b0, 12'h0, 1'b1); exe;
      rdreg(4'd1);
      checks++; if (v !== 16'h8000) begin failures++; $display("FAIL ovf_res got=%h exp=8000", v); end
      checks++; if (bus.o_cc !== 4'b0101) begin failures++; $display("FAIL ovf_cc got=%b exp=0101", bus.o_cc); end
      op_set(ADD, 4'd2, 4'd0, 1'b1, 4'h4, 1'b1, 12'h123, 1'b0);
      #1;
      checks++; if (bus.o_d_ad !== 16'h1234) begin failures++; $display("FAIL prefix_dad got=%h exp=1234", bus.o_d_ad); end
      exe;
      rdreg(4'd2);
      checks++; if (v !== 16'h1234) begin failures++; $display("FAIL prefix_res got=%h exp=1234", v); end
      op_set(ADD, 4'd3, 4'd0, 1'b1, 4'hC, 1'b0, 12'h0, 1'b0); exe;
      rdreg(4'd3);
      checks++; if (v !== 16'hFFFC) begin failures++; $display("FAIL sext_res got=%h exp=FFFC", v); end
   endtask

   task automatic test_irq_stack;
      load(4'd3, 16'h0001);
      do_reset(16'h01FE);
      clr;
      op_set(ADC, 4'd15, 4'd3, 1'b1, 4'hF, 1'b0, 12'h0, 1'b1); exe;
      checks++; if (bus.o_cc !== 4'b1010) begin failures++; $display("FAIL pre_irq_cc got=%b exp=1010", bus.o_cc); end
      op_set(ADC, 4'd14, 4'd3, 1'b1, 4'hF, 1'b0, 12'h0, 1'b1);
      bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0040; exe;
      checks++; if (bus.o_pc !== 16'h0040) begin failures++; $display("FAIL irq1_pc got=%h exp=0040", bus.o_pc); end
      checks++; if (bus.o_irq_depth !== 2'd1) begin failures++; $display("FAIL irq1_depth got=%0d exp=1", bus.o_irq_depth); end
      checks++; if (bus.o_cc !== 4'b0000) begin failures++; $display("FAIL irq1_cc got=%b exp=0000", bus.o_cc); end
      rdreg(4'd14);
      checks++; if (v !== 16'h0001) begin failures++; $display("FAIL irq1_wb got=%h exp=0001", v); end
      exe;
      op_set(SUB, 4'd15, 4'd0, 1'b1, 4'h1, 1'b0, 12'h0, 1'b1); exe;
      checks++; if (bus.o_pc !== 16'h0044) begin failures++; $display("FAIL handler_pc got=%h exp=0044", bus.o_pc); end
      bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0040; exe;
      checks++; if (bus.o_irq_depth !== 2'd2) begin failures++; $display("FAIL irq2_depth got=%0d exp=2", bus.o_irq_depth); end
      bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0040; exe;
      checks++; if ({bus.o_irq_depth, bus.o_stk_ovf} !== 3'b101) begin failures++; $display("FAIL irq3_ovf got=%b exp=101", {bus.o_irq_depth, bus.o_stk_ovf}); end
      checks++; if (bus.o_pc !== 16'h0040) begin failures++; $display("FAIL irq3_pc got=%h exp=0040", bus.o_pc); end
      bus.i_reti = 1'b1; exe;
      checks++; if (bus.o_pc !== 16'h0046) begin failures++; $display("FAIL reti1_pc got=%h exp=0046", bus.o_pc); end
      checks++; if (bus.o_cc !== 4'b0110) begin failures++; $display("FAIL reti1_cc got=%b exp=0110", bus.o_cc); end
      bus.i_reti = 1'b1; exe;
      checks++; if (bus.o_pc !== 16'h0202) begin failures++; $display("FAIL reti2_pc got=%h exp=0202", bus.o_pc); end
      checks++; if (bus.o_cc !== 4'b1010) begin failures++; $display("FAIL reti2_cc got=%b exp=1010", bus.o_cc); end
      bus.i_rf_we = 1'b1; bus.i_wb_sel = 2'd3; bus.i_rd = 4'd8; exe;
      rdreg(4'd8);
      checks++; if (v !== 16'h001A) begin failures++; $display("FAIL reti2_psw got=%h exp=001A", v); end
      bus.i_reti = 1'b1; exe;
      checks++; if ({bus.o_stk_unf, bus.o_stk_ovf, bus.o_irq_depth} !== 4'b1100) begin failures++; $display("FAIL reti3_unf got=%b exp=1100", {bus.o_stk_unf, bus.o_stk_ovf, bus.o_irq_depth}); end
      checks++; if (bus.o_pc !== 16'h0206) begin failures++; $display("FAIL reti3_pc got=%h exp=0206", bus.o_pc); end
      checks++; if (bus.o_cc !== 4'b1010) begin failures++; $display("FAIL reti3_cc got=%b exp=1010", bus.o_cc); end
   endtask

   task automatic test_branch_jal;
      do_reset(16'h0000);
      clr;
      op_set(ADD, 4'd5, 4'd0, 1'b1, 4'h0, 1'b1, 12'h300, 1'b0);
      bus.i_wb_sel = 2'd2; bus.i_is_jal = 1'b1; exe;
      checks++; if (bus.o_pc !== 16'h3000) begin failures++; $display("FAIL jal_pc got=%h exp=3000", bus.o_pc); end
      rdreg(4'd5);
      checks++; if (v !== 16'h0002) begin failures++; $display("FAIL jal_link got=%h exp=0002", v); end
      do_reset(16'h0000);
      clr;
      bus.i_br_taken = 1'b1; bus.i_disp = 8'h80; exe;
      checks++; if (bus.o_pc !== 16'hFF00) begin failures++; $display("FAIL br_wrap got=%h exp=FF00", bus.o_pc); end
      op_set(ADD, 4'd5, 4'd0, 1'b1, 4'h0, 1'b1, 12'h300, 1'b0);
      bus.i_rf_we = 1'b0; bus.i_is_jal = 1'b1; bus.i_br_taken = 1'b1; bus.i_disp = 8'h10; exe;
      checks++; if (bus.o_pc !== 16'h3000) begin failures++; $display("FAIL jal_over_br got=%h exp=3000", bus.o_pc); end
      bus.i_br_taken = 1'b1; bus.i_disp = 8'h10; exe;
      checks++; if (bus.o_pc !== 16'h3020) begin failures++; $display("FAIL br_fwd got=%h exp=3020", bus.o_pc); end
      do_reset(16'hFFFE);
      clr;
      exe;
      checks++; if (bus.o_pc !== 16'h0000) begin failures++; $display("FAIL pc2_wrap got=%h exp=0000", bus.o_pc); end
   endtask

   task automatic test_irq_reti_stall;
      do_reset(16'h0100);
      clr;
      bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0080; exe;
      checks++; if (bus.o_pc !== 16'h0080) begin failures++; $display("FAIL nest_pc got=%h exp=0080", bus.o_pc); end
      bus.i_irq_take = 1'b1; bus.i_reti = 1'b1; bus.i_irq_vector = 16'h0090; exe;
      checks++; if ({bus.o_irq_depth, bus.o_stk_unf} !== 3'b100) begin failures++; $display("FAIL both_depth got=%b exp=100", {bus.o_irq_depth, bus.o_stk_unf}); end
      checks++; if (bus.o_pc !== 16'h0090) begin failures++; $display("FAIL both_pc got=%h exp=0090", bus.o_pc); end
      bus.i_exec_ce = 1'b0; bus.i_irq_take = 1'b1; bus.i_irq_vector = 16'h0050; bus.i_rf_we = 1'b1;
      bus.i_wb_sel = 2'd1; bus.i_rd = 4'd9; bus.i_data_in = 16'hDEAD; bus.i_upd_cc = 1'b1;
      repeat (5) tick;
      checks++; if (bus.o_pc !== 16'h0090) begin failures++; $display("FAIL stall_pc got=%h exp=0090", bus.o_pc); end
      checks++; if ({bus.o_irq_depth, bus.o_stk_ovf, bus.o_cc} !== 7'b1000000) begin failures++; $display("FAIL stall_state got=%b exp=1000000", {bus.o_irq_depth, bus.o_stk_ovf, bus.o_cc}); end
      checks++; if (bus.o_data_out !== 16'h8005) begin failures++; $display("FAIL stall_rf got=%h exp=8005", bus.o_data_out); end
      clr;
      bus.i_reti = 1'b1; exe;
      checks++; if (bus.o_pc !== 16'h0082) begin failures++; $display("FAIL both_ret_pc got=%h exp=0082", bus.o_pc); end
      bus.i_reti = 1'b1; exe;
      checks++; if ({bus.o_pc, bus.o_irq_depth} !== {16'h0102, 2'd0}) begin failures++; $display("FAIL back_to_back got=%h exp=0102/0", {bus.o_pc, bus.o_irq_depth}); end
   endtask

   initial begin
      clr;
      bus.i_rst_ad = '0;
      test_reset;
      test_add_adc;
      test_sub_sbc;
      test_logic;
      test_imm;
      test_irq_stack;
      test_branch_jal;
      test_irq_reti_stall;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
